// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg -- shared definitions for the multicycle MIPS control path.
//
// Holds the main-FSM state enumeration, the opcode values the main FSM
// decodes, and the ALUOp class codes that the main FSM and the ALU decoder
// must agree on.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_e;

    // Opcode field values (instr[31:26]).
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] J     = 6'b000010;

    // ALUOp class codes consumed by the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // True when the main FSM has a path for this opcode.
    function automatic logic op_supported(input logic [5:0] op);
        return (op == LW) || (op == SW) || (op == RTYPE) ||
               (op == BEQ) || (op == ADDI) || (op == J);
    endfunction

endpackage

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm -- main control FSM of the multicycle MIPS processor.
//
// Moore machine: every output except PCEn (and the DECODE-cycle illegal_op
// flag) is a function of the registered state only.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; returns the FSM to FETCH
//   Op[5:0]    opcode from the instruction register (sampled in DECODE/MEMADR)
//   Zero       ALU zero flag, used only for PCEn in BRANCH
//   MemWrite, IRWrite, RegWrite, PCWrite, Branch   write/branch enables
//   IorD, ALUSrcA, RegDst, MemtoReg                datapath mux selects
//   ALUSrcB[1:0], PCSrc[1:0]                       datapath mux selects
//   ALUOp[1:0] class code to the ALU decoder (add / sub / use Funct)
//   PCEn       PCWrite | (Branch & Zero)
//   illegal_op pulse during DECODE when Op is unsupported
//   dbg_state  current state encoding
module multicycle_main_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Op,
    input  logic               Zero,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               IorD,
    output logic               ALUSrcA,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [1:0]         ALUOp,
    output logic               PCEn,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] out_state;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of state_d; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STATE_W'(FETCH);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Op is looked at only in DECODE and MEMADR; unused
    // encodings fall through the default back to FETCH.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = STATE_W'(FETCH);
        case (state_q)
            STATE_W'(FETCH):   state_d = STATE_W'(DECODE);
            STATE_W'(DECODE): begin
                case (Op)
                    LW, SW:  state_d = STATE_W'(MEMADR);
                    RTYPE:   state_d = STATE_W'(EXECUTE);
                    BEQ:     state_d = STATE_W'(BRANCH);
                    ADDI:    state_d = STATE_W'(ADDIEX);
                    J:       state_d = STATE_W'(JUMP);
                    default: state_d = STATE_W'(FETCH);
                endcase
            end
            STATE_W'(MEMADR):  state_d = (Op == SW) ? STATE_W'(MEMWR) : STATE_W'(MEMRD);
            STATE_W'(MEMRD):   state_d = STATE_W'(MEMWB);
            STATE_W'(EXECUTE): state_d = STATE_W'(ALUWB);
            STATE_W'(ADDIEX):  state_d = STATE_W'(ADDIWB);
            default:           state_d = STATE_W'(FETCH);
        endcase
    end

    // While reset is held the outputs present FETCH mux selects with all
    // writes suppressed, independent of whatever the register still holds.
    assign out_state = rst_n ? state_q : STATE_W'(FETCH);
    assign dbg_state = state_q;

    // Output decode.
    always_comb begin
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUOp      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (out_state)
            STATE_W'(FETCH): begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            STATE_W'(DECODE): begin
                ALUSrcB    = 2'b11;
                illegal_op = !op_supported(Op);
            end
            STATE_W'(MEMADR), STATE_W'(ADDIEX): begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            STATE_W'(MEMRD): IorD = 1'b1;
            STATE_W'(MEMWB): begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            STATE_W'(MEMWR): begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            STATE_W'(EXECUTE): begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            STATE_W'(ALUWB): begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            STATE_W'(BRANCH): begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                Branch  = 1'b1;
                PCSrc   = 2'b01;
            end
            STATE_W'(ADDIWB): RegWrite = 1'b1;
            STATE_W'(JUMP): begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            default: ;
        endcase
        if (!rst_n) begin
            IRWrite = 1'b0;
            PCWrite = 1'b0;
        end
        PCEn = PCWrite | (Branch & Zero);
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm. An instruction-level model
// produces the expected state walk for each opcode and the expected control
// word for each state; randomized opcodes, Zero values and reset hits are
// checked against it cycle by cycle.
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       Zero;
    logic       MemWrite, IRWrite, RegWrite, PCWrite, Branch;
    logic       IorD, ALUSrcA, RegDst, MemtoReg;
    logic [1:0] ALUSrcB, PCSrc, ALUOp;
    logic       PCEn, illegal_op;
    logic [3:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int exp_seq[$];

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    always #5 clk = ~clk;

    multicycle_main_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .ALUSrcA(ALUSrcA),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUOp(ALUOp), .PCEn(PCEn), .illegal_op(illegal_op),
        .dbg_state(dbg_state)
    );

    logic [14:0] act_out;
    assign act_out = {MemWrite, IRWrite, RegWrite, PCWrite, Branch, IorD,
                      ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALUOp};

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_LW || op == OP_SW || op == OP_RTYPE ||
               op == OP_BEQ || op == OP_ADDI || op == OP_J;
    endfunction

    // State walk of one instruction, FETCH first; its length is the latency.
    function automatic void build_seq(input logic [5:0] op);
        exp_seq.delete();
        exp_seq.push_back(0);
        exp_seq.push_back(1);
        case (op)
            OP_LW:    begin exp_seq.push_back(2); exp_seq.push_back(3); exp_seq.push_back(4); end
            OP_SW:    begin exp_seq.push_back(2); exp_seq.push_back(5); end
            OP_RTYPE: begin exp_seq.push_back(6); exp_seq.push_back(7); end
            OP_BEQ:   exp_seq.push_back(8);
            OP_ADDI:  begin exp_seq.push_back(9); exp_seq.push_back(10); end
            OP_J:     exp_seq.push_back(11);
            default:  ;
        endcase
    endfunction

    // Control word listed per state; in reset: FETCH selects, no writes.
    function automatic logic [14:0] exp_out(input int st, input bit in_reset);
        logic mw, irw, rw, pcw, br, iord, srca, rdst, m2r;
        logic [1:0] srcb, pcsrc, aluop;
        {mw, irw, rw, pcw, br, iord, srca, rdst, m2r} = '0;
        srcb = 2'b00; pcsrc = 2'b00; aluop = 2'b00;
        if (in_reset) begin
            srcb = 2'b01;
        end else begin
            case (st)
                0:    begin irw = 1; pcw = 1; srcb = 2'b01; end
                1:    srcb = 2'b11;
                2, 9: begin srca = 1; srcb = 2'b10; end
                3:    iord = 1;
                4:    begin rw = 1; m2r = 1; end
                5:    begin iord = 1; mw = 1; end
                6:    begin srca = 1; aluop = 2'b10; end
                7:    begin rw = 1; rdst = 1; end
                8:    begin srca = 1; aluop = 2'b01; br = 1; pcsrc = 2'b01; end
                10:   rw = 1;
                11:   begin pcw = 1; pcsrc = 2'b10; end
                default: ;
            endcase
        end
        return {mw, irw, rw, pcw, br, iord, srca, rdst, m2r, srcb, pcsrc, aluop};
    endfunction

    // Runs one instruction from FETCH. Starts and ends just after a negedge.
    // scramble: random Op/Zero outside the states where they matter.
    // reset_at: step index at which rst_n is pulled low (walk then aborts).
    task automatic run_instr(input string name, input logic [5:0] op,
                             input bit zero, input bit scramble, input int reset_at);
        int  st;
        bit  rst_now;
        bit  exp_pcen;
        bit  exp_ill;
        build_seq(op);
        for (int i = 0; i < exp_seq.size(); i++) begin
            st      = exp_seq[i];
            rst_now = (i == reset_at);
            Op      = (st == 1 || st == 2 || !scramble) ? op : 6'($urandom);
            Zero    = (st == 8 || !scramble) ? zero : 1'($urandom);
            rst_n   = !rst_now;
            #1;
            exp_pcen = !rst_now && (st == 0 || st == 11 || (st == 8 && Zero));
            exp_ill  = !rst_now && st == 1 && !is_legal(op);
            checks++;
            if (dbg_state !== 4'(st)) begin
                errors++;
                $display("FAIL %s[%0d] dbg_state got %0d want %0d", name, i, dbg_state, st);
            end
            checks++;
            if (act_out !== exp_out(st, rst_now)) begin
                errors++;
                $display("FAIL %s[%0d] ctrl got %b want %b", name, i, act_out, exp_out(st, rst_now));
            end
            checks++;
            if (PCEn !== exp_pcen) begin
                errors++;
                $display("FAIL %s[%0d] PCEn got %b want %b", name, i, PCEn, exp_pcen);
            end
            checks++;
            if (illegal_op !== exp_ill) begin
                errors++;
                $display("FAIL %s[%0d] illegal_op got %b want %b", name, i, illegal_op, exp_ill);
            end
            @(negedge clk);
            if (rst_now) begin
                rst_n = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        Op    = 6'($urandom);
        Zero  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (dbg_state !== 4'd0) begin
            errors++;
            $display("FAIL reset dbg_state got %0d want 0", dbg_state);
        end
        checks++;
        if (act_out !== exp_out(0, 1'b1)) begin
            errors++;
            $display("FAIL reset ctrl got %b want %b", act_out, exp_out(0, 1'b1));
        end
        checks++;
        if (PCEn !== 1'b0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL reset PCEn/illegal got %b%b want 00", PCEn, illegal_op);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        run_instr("lw", OP_LW, 1'b0, 1'b0, -1);
    endtask

    task automatic test_rtype();
        run_instr("rtype", OP_RTYPE, 1'b1, 1'b0, -1);
    endtask

    task automatic test_beq();
        run_instr("beq_z1", OP_BEQ, 1'b1, 1'b0, -1);
        run_instr("beq_z0", OP_BEQ, 1'b0, 1'b0, -1);
    endtask

    task automatic test_illegal();
        run_instr("illegal_3f", 6'b111111, 1'b0, 1'b0, -1);
        run_instr("illegal_01", 6'b000001, 1'b1, 1'b0, -1);
    endtask

    // Reset hits during MEMWR (step 3); the following FETCH check confirms
    // the abort.
    task automatic test_sw_reset();
        run_instr("sw_rst", OP_SW, 1'b0, 1'b0, 3);
        run_instr("after_sw_rst", OP_ADDI, 1'b0, 1'b0, -1);
    endtask

    task automatic test_op_change();
        run_instr("lw_scramble", OP_LW, 1'b0, 1'b1, -1);
        run_instr("sw_scramble", OP_SW, 1'b1, 1'b1, -1);
    endtask

    task automatic test_random();
        logic [5:0] legal[6];
        logic [5:0] op;
        int         rst_step;
        legal = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
        for (int n = 0; n < 80; n++) begin
            op       = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 5)] : 6'($urandom);
            rst_step = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr("random", op, 1'($urandom), 1'b1, rst_step);
        end
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_lw", OP_LW, 1'b0, 1'b0, -1);
        run_instr("b2b_sw", OP_SW, 1'b0, 1'b0, -1);
        run_instr("b2b_addi", OP_ADDI, 1'b0, 1'b0, -1);
        run_instr("b2b_j", OP_J, 1'b1, 1'b0, -1);
        run_instr("b2b_rtype", OP_RTYPE, 1'b0, 1'b0, -1);
        #1;
        checks++;
        if (dbg_state !== 4'd0) begin
            errors++;
            $display("FAIL b2b_end dbg_state got %0d want 0", dbg_state);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_illegal();
        test_sw_reset();
        test_op_change();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_main_fsm.md
MULTICYCLE_MAIN_FSM -- requirements
Module: multicycle_main_fsm

Interface
REQ-001 Parameter STATE_W, default 4, is the width of the state register and of the dbg_state output.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 Op  input  6  instruction opcode field, taken from the instruction register.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 MemWrite, IRWrite, RegWrite, PCWrite, Branch  output  1 each  write/branch enables.
REQ-007 IorD, ALUSrcA, RegDst, MemtoReg  output  1 each  datapath mux selects.
REQ-008 ALUSrcB, PCSrc  output  2 each  datapath mux selects.
REQ-009 ALUOp  output  2  class code to the ALU decoder: 00 add, 01 sub, 10 use Funct.
REQ-010 PCEn  output  1  PC enable, equal to PCWrite | (Branch & Zero).
REQ-011 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-012 dbg_state  output  STATE_W  current state encoding.

Function
REQ-013 The state machine is Moore: every output except PCEn SHALL depend only on the registered state.
REQ-014 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-015 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR when Op is lw 100011 or sw 101011; ->EXECUTE when Op is R-type 000000; ->BRANCH when Op is beq 000100; ->ADDIEX when Op is addi 001000; ->JUMP when Op is j 000010; ->FETCH for any other opcode.
- MEMADR->MEMRD for lw, ->MEMWR for sw.
- MEMRD->MEMWB.
- EXECUTE->ALUWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP each go ->FETCH.
REQ-016 Op SHALL be sampled in DECODE and MEMADR only; Op changes in any other state SHALL have no effect.
REQ-017 Asserted outputs per state; every unlisted output SHALL be 0:
- FETCH: IRWrite, PCWrite, ALUSrcB=01.
- DECODE: ALUSrcB=11.
- MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=10.
- MEMRD: IorD.
- MEMWB: RegWrite, MemtoReg.
- MEMWR: IorD, MemWrite.
- EXECUTE: ALUSrcA=1, ALUOp=10.
- ALUWB: RegWrite, RegDst.
- BRANCH: ALUSrcA=1, ALUOp=01, Branch, PCSrc=01.
- ADDIWB: RegWrite.
- JUMP: PCWrite, PCSrc=10.
REQ-018 Instruction latencies, counted from FETCH inclusive: lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3; illegal opcode 2.
REQ-019 illegal_op SHALL be 1 for exactly the DECODE cycle in which Op is unsupported; the following cycle is FETCH with no register or memory write.
REQ-020 An unused state encoding (12-15) SHALL transition to FETCH on the next clock.
REQ-021 In BRANCH, PCEn SHALL equal Zero; in every state other than FETCH, JUMP and BRANCH, PCEn SHALL be 0.

Reset
REQ-022 When rst_n=0 at a rising clk edge, the state SHALL become FETCH regardless of the current state, including mid-instruction.
REQ-023 While rst_n=0, MemWrite, RegWrite, IRWrite, PCWrite, PCEn and illegal_op SHALL be forced 0; the mux selects SHALL show FETCH values.
REQ-024 On the first edge with rst_n=1, the block SHALL perform a normal FETCH.

Structure
REQ-025 Package mips_ctrl_pkg SHALL hold the state enum, the opcode constants (LW, SW, RTYPE, BEQ, ADDI, J) and the ALUOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT); the existing ALUDecoder SHALL share the ALUOp constants.
REQ-026 The design SHALL be a single module with a registered state process, a combinational next-state process and a combinational output process; it SHALL have no sub-modules.

Verification
REQ-027 Op=100011 (lw): dbg_state sequence is 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-028 Op=000000 (R-type): sequence is 0,1,6,7,0; ALUOp=10 in state 6; RegWrite=1 and RegDst=1 in state 7.
REQ-029 Op=000100 (beq), run twice with Zero=1 then Zero=0: PCEn=1 then PCEn=0 in state 8; ALUOp=01.
REQ-030 Op=111111: illegal_op=1 in DECODE only; the next state is FETCH; MemWrite and RegWrite stay 0.
REQ-031 Op=101011 (sw), with rst_n driven 0 during MEMWR: MemWrite=0 in that cycle and the state is FETCH after the edge.
REQ-032 Op changes every cycle during the lw states MEMRD and MEMWB: the lw state sequence is unaffected (checks REQ-016).
